tt6502_bus_pins: RTL and testbench

Outbound external-bus sequencer for the 6502 tile: it turns a single-cycle CPU-side memory request into a multi-phase pin transaction. The address is multiplexed as two bytes on the 8 dedicated outputs, and data moves over the 8 bidirectional IOs. It is the pin-side counterpart of the chip top. The top wires `pin_addr` to `uo_out` and `pin_dout`/`pin_oe`/`pin_din` to `uio_out`/`uio_oe`/`uio_in`. Strobes and `wait` map to the remaining top-level pins.

---
 rtl/tt6502_bus_pins_if.sv | 36 +++
 rtl/tt6502_bus_pins.sv | 196 +++++++++++++++++++
 tb/tb_tt6502_bus_pins.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/tt6502_bus_pins_if.sv
// Bus bundle for tt6502_bus_pins.
// master: CPU request side plus the external pin device (drives req/we/addr/wdata,
//         pin_din and ext_wait; observes completion and pin outputs).
// slave:  the sequencer itself.
// ext_wait is the external device's "wait" pin (wait is a reserved word in SV).
interface tt6502_bus_pins_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ready;
  logic [7:0]  rdata;
  logic        err;
  logic        busy;
  logic [7:0]  pin_addr;
  logic        ale_lo;
  logic        ale_hi;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  pin_dout;
  logic [7:0]  pin_oe;
  logic [7:0]  pin_din;
  logic        ext_wait;

  modport master (
    output req, we, addr, wdata, pin_din, ext_wait,
    input  ready, rdata, err, busy, pin_addr, ale_lo, ale_hi, rd_n, wr_n,
           pin_dout, pin_oe
  );

  modport slave (
    input  req, we, addr, wdata, pin_din, ext_wait,
    output ready, rdata, err, busy, pin_addr, ale_lo, ale_hi, rd_n, wr_n,
           pin_dout, pin_oe
  );
endinterface

// File: rtl/tt6502_bus_pins.sv
// Outbound external-bus sequencer: turns a single-cycle CPU request into an
// ALO / AHI / DATA / DONE pin transaction with optional page caching of the
// address high byte and a wait-stretched, time-limited DATA phase.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   bus       - tt6502_bus_pins_if.slave: CPU request/completion and pin signals
// Parameters:
//   WAIT_MAX   - wait-extended DATA cycles allowed before abort (1..255)
//   PAGE_CACHE - skip AHI when the high address byte matches the last one driven
module tt6502_bus_pins #(
  parameter int unsigned WAIT_MAX   = 15,
  parameter bit          PAGE_CACHE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  tt6502_bus_pins_if.slave  bus
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(WAIT_MAX);

  typedef enum logic [2:0] {S_IDLE, S_ALO, S_AHI, S_DATA, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  last_hi_q, last_hi_d;
  logic        hi_valid_q, hi_valid_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic        tmo_q, tmo_d;

  logic        ready_q, ready_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [7:0]  pin_addr_q, pin_addr_d;
  logic        ale_lo_q, ale_lo_d;
  logic        ale_hi_q, ale_hi_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic [7:0]  pin_dout_q, pin_dout_d;
  logic [7:0]  pin_oe_q, pin_oe_d;

  // Next-state, captured request and page-cache update.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    last_hi_d  = last_hi_q;
    hi_valid_d = hi_valid_q;
    wcnt_d     = wcnt_q;
    tmo_d      = tmo_q;
    rdata_d    = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          tmo_d   = 1'b0;
          state_d = S_ALO;
        end
      end
      S_ALO: begin
        if (PAGE_CACHE && hi_valid_q && (addr_q[15:8] == last_hi_q)) begin
          state_d = S_DATA;
          wcnt_d  = '0;
        end else begin
          state_d = S_AHI;
        end
      end
      S_AHI: begin
        last_hi_d  = addr_q[15:8];
        hi_valid_d = 1'b1;
        wcnt_d     = '0;
        state_d    = S_DATA;
      end
      S_DATA: begin
        if (!bus.ext_wait) begin
          state_d = S_DONE;
          if (!we_q) rdata_d = bus.pin_din;
        end else if (wcnt_q == WAIT_LIMIT) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
          if (!we_q) rdata_d = 8'hFF;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pin/completion outputs decoded from the next state so they are registered
  // and line up with the state they belong to.
  always_comb begin
    ready_d    = 1'b0;
    err_d      = 1'b0;
    pin_addr_d = 8'h00;
    ale_lo_d   = 1'b0;
    ale_hi_d   = 1'b0;
    rd_n_d     = 1'b1;
    wr_n_d     = 1'b1;
    pin_dout_d = 8'h00;
    pin_oe_d   = 8'h00;
    busy_d     = (state_d != S_IDLE);

    case (state_d)
      S_ALO: begin
        pin_addr_d = addr_d[7:0];
        ale_lo_d   = 1'b1;
      end
      S_AHI: begin
        pin_addr_d = addr_d[15:8];
        ale_hi_d   = 1'b1;
      end
      S_DATA: begin
        pin_addr_d = addr_d[7:0];
        if (we_d) begin
          wr_n_d     = 1'b0;
          pin_oe_d   = 8'hFF;
          pin_dout_d = wdata_d;
        end else begin
          rd_n_d = 1'b0;
        end
      end
      S_DONE: begin
        ready_d = 1'b1;
        err_d   = tmo_d;
      end
      default: ;
    endcase
  end

  // State and output registers; reset aborts any transaction and drops the cache.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      last_hi_q  <= 8'h00;
      hi_valid_q <= 1'b0;
      wcnt_q     <= '0;
      tmo_q      <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= 8'h00;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      pin_addr_q <= 8'h00;
      ale_lo_q   <= 1'b0;
      ale_hi_q   <= 1'b0;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      pin_dout_q <= 8'h00;
      pin_oe_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      last_hi_q  <= last_hi_d;
      hi_valid_q <= hi_valid_d;
      wcnt_q     <= wcnt_d;
      tmo_q      <= tmo_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      pin_addr_q <= pin_addr_d;
      ale_lo_q   <= ale_lo_d;
      ale_hi_q   <= ale_hi_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      pin_dout_q <= pin_dout_d;
      pin_oe_q   <= pin_oe_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.rdata    = rdata_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.pin_addr = pin_addr_q;
  assign bus.ale_lo   = ale_lo_q;
  assign bus.ale_hi   = ale_hi_q;
  assign bus.rd_n     = rd_n_q;
  assign bus.wr_n     = wr_n_q;
  assign bus.pin_dout = pin_dout_q;
  assign bus.pin_oe   = pin_oe_q;

endmodule

// File: tb/tb_tt6502_bus_pins.sv
// Bench for tt6502_bus_pins: main DUT (WAIT_MAX=4, PAGE_CACHE=1) checked by a
// scoreboard monitor; a second DUT with PAGE_CACHE=0 shares the requests and
// must run AHI on every access.
module tb_tt6502_bus_pins;

  logic clk;
  logic rst;
  logic nc_rst;
  int   total;
  int   bad;
  int   issued;
  int   wait_n;
  int   nc_ready_cnt;

  typedef struct {
    logic       we;
    logic [7:0] alo;
    logic [7:0] ahi;
    logic       has_ahi;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    int         dcyc;
  } exp_t;

  exp_t sb[$];

  tt6502_bus_pins_if bus_m ();
  tt6502_bus_pins_if bus_n ();

  tt6502_bus_pins #(.WAIT_MAX(4), .PAGE_CACHE(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  tt6502_bus_pins #(.WAIT_MAX(15), .PAGE_CACHE(1'b0)) u_dut_nc (
    .clk (clk),
    .rst (nc_rst),
    .bus (bus_n)
  );

  assign bus_n.req      = bus_m.req;
  assign bus_n.we       = bus_m.we;
  assign bus_n.addr     = bus_m.addr;
  assign bus_n.wdata    = bus_m.wdata;
  assign bus_n.pin_din  = bus_m.pin_din;
  assign bus_n.ext_wait = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // Wait driver: holds ext_wait high for the first wait_n DATA cycles.
  int dcount;
  always @(negedge clk) begin
    if (!bus_m.rd_n || !bus_m.wr_n) begin
      bus_m.ext_wait = (dcount < wait_n);
      dcount++;
    end else begin
      bus_m.ext_wait = 1'b0;
      dcount = 0;
    end
  end

  // Scoreboard monitor for the main DUT.
  logic m_active;
  logic m_seen_ahi;
  int   m_cyc;
  int   m_dcyc;
  exp_t cur;
  always @(negedge clk) begin
    if (rst) begin
      m_active = 1'b0;
    end else begin
      if (m_active) m_cyc++;
      if (bus_m.ale_lo) begin
        m_active   = 1'b1;
        m_cyc      = 0;
        m_dcyc     = 0;
        m_seen_ahi = 1'b0;
        if (sb.size() == 0) chk("alo_unexpected", 1, 0);
        else begin
          cur = sb[0];
          chk("alo_addr", 32'(bus_m.pin_addr), 32'(cur.alo));
        end
      end
      if (bus_m.ale_hi) begin
        m_seen_ahi = 1'b1;
        chk("ahi_addr", 32'(bus_m.pin_addr), 32'(cur.ahi));
      end
      if (!bus_m.rd_n || !bus_m.wr_n) begin
        m_dcyc++;
        chk("data_rd_n", 32'(bus_m.rd_n), 32'(cur.we));
        chk("data_wr_n", 32'(bus_m.wr_n), 32'(!cur.we));
        chk("data_oe", 32'(bus_m.pin_oe), cur.we ? 32'hFF : 32'h00);
        chk("data_dout", 32'(bus_m.pin_dout), cur.we ? 32'(cur.wdata) : 32'h00);
        chk("data_addr", 32'(bus_m.pin_addr), 32'(cur.alo));
      end
      if (bus_m.ready) begin
        if (sb.size() == 0) chk("ready_unexpected", 1, 0);
        else begin
          cur = sb.pop_front();
          if (!cur.we) chk("rdata", 32'(bus_m.rdata), 32'(cur.rdata));
          chk("err", 32'(bus_m.err), 32'(cur.err));
          chk("ahi_seen", 32'(m_seen_ahi), 32'(cur.has_ahi));
          chk("data_cycles", 32'(m_dcyc), 32'(cur.dcyc));
          chk("latency", 32'(m_cyc), 32'(1 + int'(cur.has_ahi) + cur.dcyc));
          chk("done_idle_pins", {bus_m.pin_oe, 6'd0, bus_m.rd_n, bus_m.wr_n},
              {8'h00, 6'd0, 1'b1, 1'b1});
        end
        m_active = 1'b0;
      end
    end
  end

  // No-cache DUT monitor: every completed access must have had an AHI phase.
  logic nc_ahi_seen;
  always @(negedge clk) begin
    if (!nc_rst) begin
      if (bus_n.ale_lo) nc_ahi_seen = 1'b0;
      if (bus_n.ale_hi) nc_ahi_seen = 1'b1;
      if (bus_n.ready) begin
        nc_ready_cnt++;
        chk("nc_ahi_every", 32'(nc_ahi_seen), 1);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!bus_m.busy && !bus_n.busy) return;
      @(negedge clk);
    end
    chk("idle_timeout", 1, 0);
  endtask

  task automatic txn(input logic w, input logic [15:0] a, input logic [7:0] wd,
                     input logic [7:0] din, input int nw, input logic has_ahi,
                     input logic [7:0] exp_rd, input logic exp_err, input int dcyc);
    exp_t e;
    wait_idle();
    e.we = w; e.alo = a[7:0]; e.ahi = a[15:8]; e.has_ahi = has_ahi;
    e.wdata = wd; e.rdata = exp_rd; e.err = exp_err; e.dcyc = dcyc;
    sb.push_back(e);
    bus_m.req = 1'b1; bus_m.we = w; bus_m.addr = a; bus_m.wdata = wd;
    bus_m.pin_din = din; wait_n = nw;
    @(negedge clk);
    bus_m.req = 1'b0;
    issued++;
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    exp_t e;
    total = 0; bad = 0; issued = 0; wait_n = 0; nc_ready_cnt = 0;
    rst = 1'b1; nc_rst = 1'b1;
    bus_m.req = 1'b0; bus_m.we = 1'b0; bus_m.addr = 16'h0; bus_m.wdata = 8'h0;
    bus_m.pin_din = 8'h0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {bus_m.ready, bus_m.err, bus_m.busy}, 0);
    chk("rst_rdata", 32'(bus_m.rdata), 0);
    chk("rst_pins", {bus_m.pin_addr, bus_m.pin_dout, bus_m.pin_oe}, 0);
    chk("rst_strobes", {bus_m.ale_lo, bus_m.ale_hi, bus_m.rd_n, bus_m.wr_n}, 32'b0011);
    rst = 1'b0; nc_rst = 1'b0;
    @(negedge clk);

    //  we    addr      wdata  din    nw   ahi   rdata  err   dcyc
    txn(1'b0, 16'h1234, 8'h00, 8'h5A, 0,   1'b1, 8'h5A, 1'b0, 1); // full read
    txn(1'b1, 16'h1299, 8'hC3, 8'h00, 0,   1'b0, 8'h00, 1'b0, 1); // page-hit write
    txn(1'b0, 16'h1300, 8'h00, 8'hA5, 0,   1'b1, 8'hA5, 1'b0, 1); // page miss
    txn(1'b0, 16'h1310, 8'h00, 8'h3C, 3,   1'b0, 8'h3C, 1'b0, 4); // wait stretch
    txn(1'b0, 16'h1320, 8'h00, 8'h77, 255, 1'b0, 8'hFF, 1'b1, 5); // timeout
    txn(1'b0, 16'h2001, 8'h00, 8'h11, 0,   1'b1, 8'h11, 1'b0, 1); // normal after timeout
    txn(1'b1, 16'h2002, 8'h5E, 8'h00, 2,   1'b0, 8'h00, 1'b0, 3); // hit write, waits

    // Reset during a write DATA phase.
    wait_idle();
    e.we = 1'b1; e.alo = 8'h03; e.ahi = 8'h20; e.has_ahi = 1'b0;
    e.wdata = 8'h81; e.rdata = 8'h00; e.err = 1'b0; e.dcyc = 0;
    sb.push_back(e);
    bus_m.req = 1'b1; bus_m.we = 1'b1; bus_m.addr = 16'h2003; bus_m.wdata = 8'h81;
    wait_n = 255;
    @(negedge clk);
    bus_m.req = 1'b0;
    issued++;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!bus_m.wr_n) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_reach_data", 32'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_oe", 32'(bus_m.pin_oe), 0);
    chk("abort_wr_n", 32'(bus_m.wr_n), 1);
    chk("abort_ready", 32'(bus_m.ready), 0);
    chk("abort_busy", 32'(bus_m.busy), 0);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);

    txn(1'b0, 16'h2004, 8'h00, 8'h99, 0,   1'b1, 8'h99, 1'b0, 1); // cache invalidated

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    chk("nc_ready_count", 32'(nc_ready_cnt), 32'(issued));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
